uart_core_fifo: RTL and testbench

Parametrised full-duplex UART with a runtime-programmable baud divisor, configurable frame format (data bits, parity, stop bits) and independent TX/RX FIFOs.
- RX is 16x oversampled with glitch rejection; error flags are sticky.
- Sits behind the AXI-Lite register slave as the next-generation UART datapath.
- Replaces the fixed 8N1, unbuffered, compile-time-baud core.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_sync_fifo.sv | 42 ++++
 rtl/uart_core_fifo.sv | 181 ++++++++++++++++++
 tb/tb_uart_core_fifo.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared enums and oversampling constants for the UART core.
package uart_pkg;
    typedef enum logic [1:0] {NONE, EVEN, ODD} parity_e;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
    localparam int OVERSAMPLE      = 16;
    localparam int RX_SAMPLE_START = 7;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: register-based FIFO with first-word fall-through head and occupancy count.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    // A push while full is dropped even when a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty   = wp == rp;
    assign count   = wp - rp;
    assign dout    = mem[rp[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/uart_core_fifo.sv
// uart_core_fifo: full-duplex UART with programmable baud, frame format and TX/RX FIFOs.
// RX is 16x oversampled behind a 2-flop synchroniser; error flags are sticky.
module uart_core_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [DIV_WIDTH-1:0]          Baud_div,
    input  logic                          Enable_tx,
    input  logic                          Enable_rx,
    input  logic                          Wr_en,
    input  logic [DATA_BITS-1:0]          Tx_data,
    output logic                          Tx_full,
    output logic [$clog2(FIFO_DEPTH):0]   Tx_count,
    input  logic                          Rd_en,
    output logic [DATA_BITS-1:0]          Rx_data,
    output logic                          Empty,
    output logic [$clog2(FIFO_DEPTH):0]   Rx_count,
    input  logic                          Err_clr,
    output logic                          Parity_error,
    output logic                          Frame_error,
    output logic                          Overrun,
    input  logic                          RX,
    output logic                          TX
);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam bit HAS_PAR = PARITY != int'(NONE);
    localparam bit ODD_PAR = PARITY == int'(ODD);
    localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [4:0] RX_START  = 5'(RX_SAMPLE_START);
    logic [DIV_WIDTH-1:0] div_cnt;
    logic tick;
    assign tick = div_cnt == '0;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) div_cnt <= '0;
        else       div_cnt <= tick ? Baud_div : div_cnt - 1'b1;
    end
    logic [DATA_BITS-1:0] tx_head;
    logic tx_empty, tx_pop;
    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(Clk), .rst(Reset), .push(Wr_en), .pop(tx_pop), .din(Tx_data),
        .dout(tx_head), .full(Tx_full), .empty(tx_empty), .count(Tx_count)
    );
    uart_state_e tx_state, tx_next;
    logic [4:0] tx_tcnt;
    logic [IW-1:0] tx_idx;
    logic [DATA_BITS-1:0] tx_sh;
    logic tx_par, tx_bit_end;
    assign tx_bit_end = tick && tx_tcnt == (tx_state == STOP ? STOP_LAST : BIT_LAST);
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            IDLE: if (Enable_tx && !tx_empty) begin
                tx_pop  = 1'b1;
                tx_next = START;
            end
            START: if (tx_bit_end) tx_next = DATA;
            DATA: if (tx_bit_end && tx_idx == IW'(DATA_BITS - 1)) begin
                if (HAS_PAR) tx_next = uart_pkg::PARITY;
                else         tx_next = STOP;
            end
            uart_pkg::PARITY: if (tx_bit_end) tx_next = STOP;
            // Chain straight into the next start bit so back-to-back frames have no idle gap.
            STOP: if (tx_bit_end) begin
                if (Enable_tx && !tx_empty) begin
                    tx_pop  = 1'b1;
                    tx_next = START;
                end else tx_next = IDLE;
            end
            default: tx_next = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tx_state <= IDLE;
            tx_tcnt  <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_pop) begin
                tx_sh   <= tx_head;
                tx_par  <= ^tx_head ^ ODD_PAR;
                tx_tcnt <= '0;
                tx_idx  <= '0;
            end else if (tick) begin
                tx_tcnt <= tx_bit_end ? '0 : tx_tcnt + 1'b1;
                if (tx_bit_end && tx_state == DATA) begin
                    tx_sh  <= tx_sh >> 1;
                    tx_idx <= tx_idx + 1'b1;
                end
            end
        end
    end
    assign TX = tx_state == START ? 1'b0 :
                tx_state == DATA ? tx_sh[0] :
                tx_state == uart_pkg::PARITY ? tx_par : 1'b1;
    logic rs1, rs2, rs3;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) {rs1, rs2, rs3} <= 3'b111;
        else       {rs1, rs2, rs3} <= {RX, rs1, rs2};
    end
    uart_state_e rx_state, rx_next;
    logic [4:0] rx_tcnt;
    logic [IW-1:0] rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic rx_sample, rx_push, rx_full, set_pe, set_fe;
    assign rx_sample = tick && rx_tcnt == (rx_state == START ? RX_START : BIT_LAST);
    always_comb begin
        rx_next = rx_state;
        rx_push = 1'b0;
        set_pe  = 1'b0;
        set_fe  = 1'b0;
        if (!Enable_rx) rx_next = IDLE;
        else case (rx_state)
            IDLE: if (rs3 && !rs2) rx_next = START;
            START: if (rx_sample) begin
                if (rs2) rx_next = IDLE;
                else     rx_next = DATA;
            end
            DATA: if (rx_sample && rx_idx == IW'(DATA_BITS - 1)) begin
                if (HAS_PAR) rx_next = uart_pkg::PARITY;
                else         rx_next = STOP;
            end
            uart_pkg::PARITY: if (rx_sample) begin
                rx_next = STOP;
                set_pe  = rs2 != (^rx_sh ^ ODD_PAR);
            end
            STOP: if (rx_sample) begin
                rx_next = IDLE;
                set_fe  = !rs2;
                rx_push = rs2;
            end
            default: rx_next = IDLE;
        endcase
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_state <= IDLE;
            rx_tcnt  <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == IDLE) begin
                rx_tcnt <= '0;
                rx_idx  <= '0;
            end else if (tick) begin
                rx_tcnt <= rx_sample ? '0 : rx_tcnt + 1'b1;
                if (rx_sample && rx_state == DATA) begin
                    rx_sh  <= {rs2, rx_sh[DATA_BITS-1:1]};
                    rx_idx <= rx_idx + 1'b1;
                end
            end
        end
    end
    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(Clk), .rst(Reset), .push(rx_push), .pop(Rd_en), .din(rx_sh),
        .dout(Rx_data), .full(rx_full), .empty(Empty), .count(Rx_count)
    );
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Parity_error <= 1'b0;
            Frame_error  <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            Parity_error <= set_pe | (Parity_error & ~Err_clr);
            Frame_error  <= set_fe | (Frame_error & ~Err_clr);
            Overrun      <= (rx_push & rx_full) | (Overrun & ~Err_clr);
        end
    end
endmodule

// File: tb/tb_uart_core_fifo.sv
// tb_uart_core_fifo: scoreboard bench for uart_core_fifo (8E1, Baud_div=3 -> 64 cycles/bit).
// Monitors decode TX frames and RX FIFO reads against queues filled by the stimulus.
module tb_uart_core_fifo;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Baud_div;
    logic        Enable_tx, Enable_rx, Wr_en, Rd_en, Err_clr;
    logic [7:0]  Tx_data, Rx_data;
    logic        Tx_full, Empty, Parity_error, Frame_error, Overrun, TX, RX;
    logic [4:0]  Tx_count, Rx_count;
    logic        rx_drv, loop, tx_mon;
    int checks = 0;
    int fails = 0;
    logic [10:0] tx_exp[$];
    logic [7:0]  rx_exp[$];

    assign RX = loop ? TX : rx_drv;
    always #5 Clk = ~Clk;

    uart_core_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1), .DIV_WIDTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .Baud_div(Baud_div), .Enable_tx(Enable_tx), .Enable_rx(Enable_rx),
        .Wr_en(Wr_en), .Tx_data(Tx_data), .Tx_full(Tx_full), .Tx_count(Tx_count), .Rd_en(Rd_en),
        .Rx_data(Rx_data), .Empty(Empty), .Rx_count(Rx_count), .Err_clr(Err_clr),
        .Parity_error(Parity_error), .Frame_error(Frame_error), .Overrun(Overrun), .RX(RX), .TX(TX)
    );

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_tx(input logic [7:0] d, input bit expect_frame);
        @(posedge Clk); #1;
        Wr_en = 1'b1;
        Tx_data = d;
        if (expect_frame) tx_exp.push_back(frame_of(d));
    endtask

    task automatic idle_tx();
        @(posedge Clk); #1;
        Wr_en = 1'b0;
    endtask

    task automatic read_rx(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk); #1 Rd_en = 1'b1;
            @(posedge Clk); #1 Rd_en = 1'b0;
        end
    endtask

    task automatic clear_err();
        @(posedge Clk); #1 Err_clr = 1'b1;
        @(posedge Clk); #1 Err_clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] f;
        f = frame_of(d);
        f[9] = f[9] ^ bad_par;
        if (bad_stop) f[10] = 1'b0;
        for (int b = 0; b < 11; b++) begin
            rx_drv = f[b];
            repeat (64) @(posedge Clk);
        end
        rx_drv = 1'b1;
        repeat (64) @(posedge Clk);
    endtask

    task automatic wait_rx_count(input int n, input int budget);
        int i;
        i = 0;
        while (Rx_count != 5'(n) && i < budget) begin
            @(negedge Clk);
            i++;
        end
        check("rx_count_wait", Rx_count, n);
    endtask

    // TX monitor: sample mid-bit from the falling start edge and compare the whole frame.
    initial begin
        logic [10:0] f;
        forever begin
            @(negedge Clk);
            if (tx_mon && !Reset && TX === 1'b0) begin
                repeat (30) @(negedge Clk);
                f[0] = TX;
                for (int b = 1; b < 11; b++) begin
                    repeat (64) @(negedge Clk);
                    f[b] = TX;
                end
                if (tx_exp.size() == 0) check("tx_unexpected_frame", f, 11'h0);
                else check("tx_frame", f, tx_exp.pop_front());
            end
        end
    end

    // RX monitor: every accepted pop is compared against the expected byte order.
    initial begin
        forever begin
            @(negedge Clk);
            if (Rd_en && !Empty) begin
                if (rx_exp.size() == 0) check("rx_unexpected_byte", {24'h1, Rx_data}, 32'h0);
                else check("rx_data", Rx_data, rx_exp.pop_front());
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Baud_div = 16'd3; Enable_tx = 1'b0; Enable_rx = 1'b0;
        Wr_en = 1'b0; Tx_data = 8'h00; Rd_en = 1'b0; Err_clr = 1'b0;
        rx_drv = 1'b1; loop = 1'b0; tx_mon = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_tx", TX, 1);
        check("rst_tx_full", Tx_full, 0);
        check("rst_tx_count", Tx_count, 0);
        check("rst_empty", Empty, 1);
        check("rst_rx_count", Rx_count, 0);
        check("rst_rx_data", Rx_data, 0);
        check("rst_flags", {Parity_error, Frame_error, Overrun}, 0);
        @(posedge Clk); #1 Reset = 1'b0;

        // Single 0xA5 frame, checking the pop and start-bit timing.
        Enable_tx = 1'b1;
        push_tx(8'hA5, 1'b1);
        idle_tx();
        @(negedge Clk);
        check("a5_count_after_push", Tx_count, 1);
        check("a5_tx_idle_before_pop", TX, 1);
        @(negedge Clk);
        check("a5_count_after_pop", Tx_count, 0);
        check("a5_tx_start", TX, 0);
        repeat (800) @(negedge Clk);

        // Loopback of three back-to-back frames.
        loop = 1'b1;
        Enable_rx = 1'b1;
        push_tx(8'h00, 1'b1);
        push_tx(8'hFF, 1'b1);
        push_tx(8'h5A, 1'b1);
        idle_tx();
        rx_exp.push_back(8'h00);
        rx_exp.push_back(8'hFF);
        rx_exp.push_back(8'h5A);
        wait_rx_count(3, 4000);
        check("loop_flags", {Parity_error, Frame_error, Overrun}, 0);
        read_rx(3);
        @(negedge Clk);
        check("loop_empty", Empty, 1);
        repeat (200) @(negedge Clk);

        // Seventeen frames into a sixteen-entry RX FIFO.
        for (int i = 0; i < 17; i++) begin
            push_tx(8'h10 + 8'(i), 1'b1);
            if (i < 16) rx_exp.push_back(8'h10 + 8'(i));
        end
        idle_tx();
        begin
            int n;
            n = 0;
            while (!Overrun && n < 16000) begin
                @(negedge Clk);
                n++;
            end
        end
        check("ovr_flag", Overrun, 1);
        check("ovr_rx_count", Rx_count, 16);
        check("ovr_other_flags", {Parity_error, Frame_error}, 0);
        read_rx(16);
        @(negedge Clk);
        check("ovr_drained", Empty, 1);
        clear_err();
        @(negedge Clk);
        check("ovr_cleared", Overrun, 0);
        repeat (400) @(negedge Clk);

        // Directly driven frames with a bad stop bit, then a bad parity bit.
        loop = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b1);
        check("fe_flag", Frame_error, 1);
        check("fe_empty", Empty, 1);
        check("fe_no_pe", Parity_error, 0);
        clear_err();
        @(negedge Clk);
        check("fe_cleared", Frame_error, 0);
        rx_exp.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0);
        check("pe_flag", Parity_error, 1);
        check("pe_no_fe", Frame_error, 0);
        check("pe_rx_count", Rx_count, 1);
        read_rx(1);
        clear_err();
        @(negedge Clk);
        check("pe_cleared", Parity_error, 0);

        // Four-tick glitch must be rejected; the next real frame must still land.
        rx_drv = 1'b0;
        repeat (16) @(posedge Clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge Clk);
        check("glitch_empty", Empty, 1);
        check("glitch_flags", {Parity_error, Frame_error, Overrun}, 0);
        rx_exp.push_back(8'h81);
        send_frame(8'h81, 1'b0, 1'b0);
        wait_rx_count(1, 200);
        read_rx(1);
        check("tx_frames_pending", tx_exp.size(), 0);

        // TX FIFO fill with the transmitter disabled; the 17th write is dropped.
        Enable_tx = 1'b0;
        for (int i = 0; i < 15; i++) push_tx(8'h00, 1'b0);
        idle_tx();
        @(negedge Clk);
        check("fill15_full", Tx_full, 0);
        check("fill15_count", Tx_count, 15);
        push_tx(8'h00, 1'b0);
        push_tx(8'h00, 1'b0);
        idle_tx();
        @(negedge Clk);
        check("fill17_full", Tx_full, 1);
        check("fill17_count", Tx_count, 16);

        // Reset while both FSMs are mid-DATA.
        tx_mon = 1'b0;
        Enable_tx = 1'b1;
        rx_drv = 1'b0;
        repeat (64) @(posedge Clk);
        rx_drv = 1'b1;
        repeat (40) @(posedge Clk);
        @(negedge Clk);
        check("mid_tx_low", TX, 0);
        check("mid_tx_count", Tx_count, 15);
        #1 Reset = 1'b1;
        #1;
        check("arst_tx", TX, 1);
        check("arst_tx_count", Tx_count, 0);
        check("arst_tx_full", Tx_full, 0);
        check("arst_rx_count", Rx_count, 0);
        check("arst_empty", Empty, 1);
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        tx_mon = 1'b1;
        rx_exp.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b0);
        wait_rx_count(1, 200);
        read_rx(1);
        @(negedge Clk);
        check("post_rst_flags", {Parity_error, Frame_error, Overrun}, 0);
        check("rx_bytes_pending", rx_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
